// File: rtl/bless_ni.sv
// Local network interface for the age-based bufferless router: an ageing injection FIFO
// toward router port 4 and a control/data re-pairing stage on the ejection side.
module bless_ni #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AGE_W = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [27:0]              core_c,
  input  logic [127:0]             core_d,
  input  logic                     core_valid,
  output logic                     core_ready,
  input  logic                     port4_ready,
  output logic [27:0]              inj_c,
  output logic [127:0]             inj_d,
  input  logic [27:0]              port4_co,
  input  logic [127:0]             port4_do,
  output logic                     ej_valid,
  output logic [27:0]              ej_c,
  output logic [127:0]             ej_d,
  output logic [$clog2(DEPTH):0]   q_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [19:0]      mem_c   [DEPTH];
  logic [127:0]     mem_d   [DEPTH];
  logic [AGE_W-1:0] mem_age [DEPTH];

  logic [PW-1:0]  head_q, tail_q;
  logic [CW-1:0]  count_q, count_d;
  logic [127:0]   stage_q;
  logic           pop_q;
  logic [27:0]    lat_q;
  logic           pend_q;
  logic           push, pop;

  // Valid and age bits of the core's control word are regenerated here.
  logic unused_core_c;
  assign unused_core_c = ^core_c[27:20];

  assign core_ready = (count_q != CW'(DEPTH));
  assign push       = core_valid && core_ready;
  assign pop        = port4_ready && (count_q != '0);
  assign q_count    = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_c[tail_q] <= core_c[19:0];
      mem_d[tail_q] <= core_d;
    end
  end

  // Every slot ages each edge; vacant slots are harmless because a push restarts them at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_age[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (push && (tail_q == PW'(i))) begin
          mem_age[i] <= '0;
        end else if (mem_age[i] != '1) begin
          mem_age[i] <= mem_age[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      count_q <= count_d;
      if (push) tail_q <= tail_q + 1'b1;
      if (pop)  head_q <= head_q + 1'b1;
    end
  end

  // Control goes out on the pop edge; its data follows one edge later via the staging register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inj_c   <= '0;
      inj_d   <= '0;
      stage_q <= '0;
      pop_q   <= 1'b0;
    end else begin
      inj_c <= pop ? {1'b1, mem_age[head_q], mem_c[head_q]} : 28'h0;
      if (pop) stage_q <= mem_d[head_q];
      pop_q <= pop;
      inj_d <= pop_q ? stage_q : 128'h0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lat_q    <= '0;
      pend_q   <= 1'b0;
      ej_valid <= 1'b0;
      ej_c     <= '0;
      ej_d     <= '0;
    end else begin
      if (port4_co[27]) lat_q <= port4_co;
      pend_q   <= port4_co[27];
      ej_valid <= pend_q;
      if (pend_q) begin
        ej_c <= lat_q;
        ej_d <= port4_do;
      end
    end
  end

endmodule

// File: tb/tb_bless_ni.sv
// Scoreboard bench for bless_ni: a reference queue model predicts injected and ejected flits.
module tb_bless_ni;

  localparam int unsigned DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [27:0]  core_c;
  logic [127:0] core_d;
  logic         core_valid;
  logic         core_ready;
  logic         port4_ready;
  logic [27:0]  inj_c;
  logic [127:0] inj_d;
  logic [27:0]  port4_co;
  logic [127:0] port4_do;
  logic         ej_valid;
  logic [27:0]  ej_c;
  logic [127:0] ej_d;
  logic [2:0]   q_count;

  bless_ni #(.DEPTH(DEPTH), .AGE_W(7)) dut (
    .clk(clk), .rst(rst), .core_c(core_c), .core_d(core_d), .core_valid(core_valid),
    .core_ready(core_ready), .port4_ready(port4_ready), .inj_c(inj_c), .inj_d(inj_d),
    .port4_co(port4_co), .port4_do(port4_do), .ej_valid(ej_valid), .ej_c(ej_c),
    .ej_d(ej_d), .q_count(q_count)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [19:0]  mq_c   [$];
  logic [127:0] mq_d   [$];
  int           mq_age [$];
  logic         m_dpend;
  logic         m_pend;
  logic [27:0]  m_lat;
  logic [27:0]  m_ejc;
  logic [127:0] m_ejd;

  // Scoreboard queues
  logic [27:0]  sb_c  [$];
  logic [127:0] sb_d  [$];
  logic [27:0]  sb_ec [$];
  logic [127:0] sb_ed [$];

  task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic model_clear();
    mq_c.delete(); mq_d.delete(); mq_age.delete();
    sb_c.delete(); sb_d.delete(); sb_ec.delete(); sb_ed.delete();
    m_dpend = 1'b0; m_pend = 1'b0; m_lat = '0; m_ejc = '0; m_ejd = '0;
  endtask

  task automatic idle_inputs();
    core_valid = 1'b0; core_c = '0; core_d = '0;
    port4_ready = 1'b0; port4_co = '0; port4_do = '0;
  endtask

  // One clock edge: advance the model with the current inputs, then compare DUT outputs.
  task automatic tick();
    bit push, pop, exp_ej;
    push = core_valid && (mq_c.size() < DEPTH);
    pop  = port4_ready && (mq_c.size() > 0);
    if (pop) begin
      sb_c.push_back({1'b1, 7'(mq_age[0]), mq_c[0]});
      sb_d.push_back(mq_d[0]);
      void'(mq_c.pop_front()); void'(mq_d.pop_front()); void'(mq_age.pop_front());
    end
    foreach (mq_age[i]) if (mq_age[i] < 127) mq_age[i]++;
    if (push) begin
      mq_c.push_back(core_c[19:0]); mq_d.push_back(core_d); mq_age.push_back(0);
    end
    exp_ej = m_pend;
    if (m_pend) begin
      sb_ec.push_back(m_lat); sb_ed.push_back(port4_do);
      m_ejc = m_lat; m_ejd = port4_do;
    end
    m_pend = port4_co[27];
    if (port4_co[27]) m_lat = port4_co;

    @(posedge clk); #1;

    if (inj_c[27] || sb_c.size() != 0) begin
      if (sb_c.size() == 0) check("inj_c_extra", inj_c, 128'h0);
      else check("inj_c", inj_c, sb_c.pop_front());
    end else check("inj_c_idle", inj_c, 128'h0);
    if (m_dpend && sb_d.size() != 0) check("inj_d", inj_d, sb_d.pop_front());
    else check("inj_d_idle", inj_d, 128'h0);
    m_dpend = pop;

    check("ej_valid", ej_valid, exp_ej);
    if (ej_valid && sb_ec.size() != 0) begin
      check("ej_c", ej_c, sb_ec.pop_front());
      check("ej_d", ej_d, sb_ed.pop_front());
    end else begin
      check("ej_c_hold", ej_c, m_ejc);
      check("ej_d_hold", ej_d, m_ejd);
    end
    check("q_count", q_count, mq_c.size());
    check("core_ready", core_ready, mq_c.size() != DEPTH);
  endtask

  task automatic push_one(input logic [27:0] c, input logic [127:0] d);
    core_valid = 1'b1; core_c = c; core_d = d;
    tick();
    core_valid = 1'b0;
  endtask

  initial begin
    idle_inputs();
    model_clear();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_inj_c", inj_c, 128'h0);
    check("rst_inj_d", inj_d, 128'h0);
    check("rst_ej_valid", ej_valid, 128'h0);
    check("rst_ej_c", ej_c, 128'h0);
    check("rst_ej_d", ej_d, 128'h0);
    check("rst_q_count", q_count, 128'h0);
    check("rst_core_ready", core_ready, 128'h1);
    @(negedge clk) rst = 1'b1;

    // Single flit, immediate grant
    port4_ready = 1'b1;
    push_one(28'h0000001, 128'h0123456789abcdef0123456789abcdef);
    tick();
    check("t1_inj_c", inj_c, 128'h8000001);
    tick();
    check("t1_inj_d", inj_d, 128'h0123456789abcdef0123456789abcdef);
    tick();
    check("t1_c_zero", inj_c, 128'h0);
    check("t1_d_zero", inj_d, 128'h0);

    // Age 5, then saturation; upper core_c bits must be ignored
    port4_ready = 1'b0;
    push_one(28'hFF00001, 128'h5);
    repeat (5) tick();
    port4_ready = 1'b1;
    tick();
    check("age5", inj_c, 128'h8500001);
    tick();
    port4_ready = 1'b0;
    push_one(28'h0000001, 128'h6);
    repeat (200) tick();
    port4_ready = 1'b1;
    tick();
    check("age_sat", inj_c, 128'hFF00001);
    repeat (2) tick();

    // Fill to full, reject fifth push, drain in order
    port4_ready = 1'b0;
    for (int i = 0; i < 4; i++) push_one(28'(32'h100 + i), 128'(64'hD000 + i));
    check("full_count", q_count, 128'h4);
    check("full_ready", core_ready, 128'h0);
    push_one(28'h00000FF, 128'hBAD);
    check("full_ignore", q_count, 128'h4);
    port4_ready = 1'b1;
    repeat (6) tick();
    check("drained", q_count, 128'h0);

    // Simultaneous push and pop at occupancy 2
    port4_ready = 1'b0;
    push_one(28'h0000201, 128'h201);
    push_one(28'h0000202, 128'h202);
    port4_ready = 1'b1;
    push_one(28'h0000203, 128'h203);
    check("pushpop_count", q_count, 128'h2);
    repeat (4) tick();

    // Random traffic across several pointer wraps
    for (int i = 0; i < 8 * DEPTH; i++) begin
      core_valid  = 1'($urandom_range(0, 1));
      core_c      = 28'($urandom);
      core_d      = {$urandom, $urandom, $urandom, $urandom};
      port4_ready = 1'($urandom_range(0, 1));
      tick();
    end
    core_valid = 1'b0; port4_ready = 1'b1;
    repeat (DEPTH + 2) tick();
    check("wrap_empty", q_count, 128'h0);
    port4_ready = 1'b0;

    // Ejection: single, then back-to-back
    port4_co = 28'h8000003; tick();
    port4_co = '0; port4_do = {16{8'hAA}}; tick();
    check("ej1_valid", ej_valid, 128'h1);
    check("ej1_c", ej_c, 128'h8000003);
    check("ej1_d", ej_d, {16{8'hAA}});
    port4_do = '0; tick();
    check("ej1_pulse", ej_valid, 128'h0);
    port4_co = 28'h8000011; tick();
    port4_co = 28'h8000022; port4_do = {16{8'hBB}}; tick();
    port4_co = '0; port4_do = {16{8'hCC}}; tick();
    port4_do = '0; tick();
    tick();

    // Reset between a flit's control and data cycles
    port4_ready = 1'b1;
    push_one(28'h0000001, 128'hFACE);
    tick();
    check("mid_inj_c", inj_c, 128'h8000001);
    rst = 1'b0;
    #1;
    check("mid_rst_c", inj_c, 128'h0);
    check("mid_rst_d", inj_d, 128'h0);
    check("mid_rst_ejv", ej_valid, 128'h0);
    check("mid_rst_cnt", q_count, 128'h0);
    check("mid_rst_rdy", core_ready, 128'h1);
    model_clear();
    @(posedge clk); #1;
    check("mid_rst_d_hold", inj_d, 128'h0);
    @(negedge clk) rst = 1'b1;
    push_one(28'h0000005, 128'h1234);
    tick();
    check("post_rst_c", inj_c, 128'h8000005);
    tick();
    check("post_rst_d", inj_d, 128'h1234);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bless_ni.md
Name: bless_ni

Overview:
- Local network interface for the age-based bufferless router. It connects the core to router port 4 (local inject/eject).
- Inject path: queues core flits, stamps each with its age (cycles waited), and injects into the router only when the router grants injection.
- Eject path: reassembles the router's split control/data ejection stream into single-cycle flits for the core.
- Flit format is the router's: 28-bit control word, then 128-bit data word one cycle later.

Parameters:
DEPTH, 4, injection queue entries (power of two, >=2)
AGE_W, 7, age field width; fixed at 7 by the control-word layout

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; asynchronous, active-low (clears all state while 0)
core_c  in  28  control word from core; bits [27] and [26:20] ignored
core_d  in  128  data word from core, same cycle as core_c
core_valid  in  1  core push request
core_ready  out  1  queue can accept a push this cycle
port4_ready  in  1  router grants injection this cycle
inj_c  out  28  control word to router port4_ci
inj_d  out  128  data word to router port4_di
port4_co  in  28  ejected control word from router
port4_do  in  128  ejected data word from router, one cycle after its control
ej_valid  out  1  ejected flit valid, one-cycle pulse
ej_c  out  28  ejected control word
ej_d  out  128  ejected data word
q_count  out  log2(DEPTH)+1  current queue occupancy

Behaviour:
- Control layout:
  - [27] valid.
  - [26:20] age.
  - [19:0] routing/destination, passed through unchanged.
- Reset (rst=0, async):
  - Queue empty, q_count=0, core_ready=1.
  - inj_c=0, inj_d=0, ej_valid=0, ej_c=0, ej_d=0.
  - Eject capture state cleared.
- core_ready = (q_count != DEPTH). It is combinational from registered state only; it does not depend on a same-cycle pop.
- Push: on an edge with core_valid && core_ready, enqueue {core_c[19:0], core_d} at the tail. The entry's age is 0.
- Age:
  - Every resident entry not popped at an edge increments its age by 1.
  - Age saturates at 127.
  - An entry pushed at edge E and popped at E+1 carries age 0.
- Pop: on an edge with port4_ready && q_count != 0:
  - Head is dequeued.
  - inj_c <= {1'b1, age, head[19:0]}.
  - Head data is moved to a staging register.
  - When the queue is empty or port4_ready=0, inj_c <= 0.
- Data timing:
  - inj_d is registered and, at each edge, loads the staging register if a pop occurred at the previous edge; otherwise it loads 0.
  - So inj_d carries the data of the flit whose control appeared on inj_c one cycle earlier.
  - Back-to-back pops give a pipelined control/data stream.
- Simultaneous push and pop: both happen, q_count unchanged. Not possible when full, because core_ready=0.
- Order: strict FIFO. Head/tail pointers wrap modulo DEPTH.
- Eject:
  - On an edge where port4_co[27]=1, latch port4_co and set a pending flag.
  - At the next edge: ej_d <= port4_do, ej_c <= latched control, ej_valid <= 1.
  - Otherwise ej_valid <= 0; ej_c and ej_d hold.
  - Back-to-back ejections are pipelined: the latch and the output stage can each be full in the same cycle.
  - There is no backpressure; the core must accept every ej_valid pulse.
- Reset mid-injection: a flit whose control has already gone out loses its data word; inj_d is forced to 0. The router treats this as reset too.

Test Plan:
- Push core_c=0x0000001, core_d=0x0123456789abcdef0123456789abcdef with port4_ready=1 -> next edge inj_c=0x8000001; following edge inj_d=0x0123456789abcdef0123456789abcdef; then inj_c=inj_d=0.
- Push dest 0x00001, hold port4_ready=0 for 5 edges, then raise it -> inj_c=0x8500001. Hold for 200 edges instead -> inj_c=0xFF00001 (age saturates at 127).
- Four pushes with port4_ready=0 -> q_count=4, core_ready=0, fifth push ignored. Then port4_ready=1 for 4 cycles -> four flits out in push order, inj_d lagging inj_c by exactly one cycle, q_count returns to 0.
- Queue at 2, push and pop on the same edge -> q_count stays 2. Pointer wrap after 3×DEPTH flits -> no reordering and no loss.
- Ejection sequence:
  - port4_co=0x8000003, next cycle port4_do=0xAA..AA -> one-cycle ej_valid with ej_c=0x8000003, ej_d=0xAA..AA.
  - Two consecutive ejections -> two consecutive ej_valid pulses, each with correct pairing.
- Drop rst to 0 between inj_c=0x8000001 and its data cycle -> inj_c, inj_d, ej_valid go 0 immediately, q_count=0, core_ready=1. After release, a fresh push injects normally.
